// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU with status flags
//
// Purpose: registered ALU between register-file read and writeback. The
//   logic ops, ADD, SUB and SHL by zero complete in one cycle. SHL by k>0
//   takes k steps, and MUL takes WIDTH shift-add steps.
// Configuration macro: ALU_MUL_EN (defined: opcode 111 is the shift-add
//   multiplier; undefined: opcode 111 returns zero in one cycle).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake (in_ready only in IDLE)
//   A, B, ALUOp               operands and opcode, captured at acceptance
//   out_valid/out_ready       result handshake (held until accepted)
//   Result, Zero, Negative, Carry, Overflow   registered result and flags
//   busy                      high while a multi-cycle op executes
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             busy
);

  // Counter must hold WIDTH itself, hence one bit wider than the shift field.
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_acc;
  logic [WIDTH:0]   sh_step;   // [WIDTH] is the bit shifted out this step
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic [WIDTH:0]   sum_ext;

`ifdef ALU_MUL_EN
  logic               mul_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod_next;

  assign prod_next = prod + (mplier[0] ? mcand : '0);
`endif

  assign sh_step = {sh_acc, 1'b0};

  // Single-cycle results, computed straight from the operands being accepted.
  always_comb begin
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sum_ext = '0;
    case (ALUOp)
      3'b000: begin
        sum_ext = {1'b0, A} + {1'b0, B};
        sc_res  = sum_ext[WIDTH-1:0];
        sc_c    = sum_ext[WIDTH];
        sc_v    = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: begin
        // Carry-out of A + ~B + 1: 1 means no borrow.
        sum_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        sc_res  = sum_ext[WIDTH-1:0];
        sc_c    = sum_ext[WIDTH];
        sc_v    = (A[WIDTH-1] != B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010:  sc_res = A & B;
      3'b011:  sc_res = A | B;
      3'b100:  sc_res = ~A;
      3'b101:  sc_res = A ^ B;
      3'b110:  sc_res = A;      // only reached with a zero shift amount
      default: sc_res = '0;     // 111 without the multiplier
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      cnt       <= '0;
      sh_acc    <= '0;
`ifdef ALU_MUL_EN
      mul_q     <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (ALUOp == 3'b110 && B[SHW-1:0] != '0) begin
              sh_acc <= A;
              cnt    <= {1'b0, B[SHW-1:0]};
              busy   <= 1'b1;
              state  <= S_EXEC;
`ifdef ALU_MUL_EN
              mul_q  <= 1'b0;
`endif
            end
`ifdef ALU_MUL_EN
            else if (ALUOp == 3'b111) begin
              mul_q  <= 1'b1;
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              cnt    <= CW'(WIDTH);
              busy   <= 1'b1;
              state  <= S_EXEC;
            end
`endif
            else begin
              Result    <= sc_res;
              Zero      <= (sc_res == '0);
              Negative  <= sc_res[WIDTH-1];
              Carry     <= sc_c;
              Overflow  <= sc_v;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_EXEC: begin
          cnt    <= cnt - CW'(1);
          sh_acc <= sh_step[WIDTH-1:0];
`ifdef ALU_MUL_EN
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`endif
          // Last step: register the value produced by this step directly.
          if (cnt == CW'(1)) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            Overflow  <= 1'b0;
            state     <= S_DONE;
`ifdef ALU_MUL_EN
            if (mul_q) begin
              Result   <= prod_next[WIDTH-1:0];
              Zero     <= (prod_next[WIDTH-1:0] == '0);
              Negative <= prod_next[WIDTH-1];
              Carry    <= |prod_next[2*WIDTH-1:WIDTH];
            end else begin
`else
            begin
`endif
              Result   <= sh_step[WIDTH-1:0];
              Zero     <= (sh_step[WIDTH-1:0] == '0);
              Negative <= sh_step[WIDTH-1];
              Carry    <= sh_step[WIDTH];
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=16)
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALUOp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and step through its acceptance edge; operands are
  // then scrambled so a design that does not capture them gets caught.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    A = a; B = b; ALUOp = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b; ALUOp = ~op;
  endtask

  // Latency counted in edges from the acceptance edge inclusive.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] res,
                         input logic [3:0] zncv, input int lat);
    int l;
    start_op(a, b, op);
    wait_done(l);
    check({tag, "_lat"}, l, lat);
    check({tag, "_res"}, {16'd0, Result}, {16'd0, res});
    check({tag, "_zncv"}, {28'd0, Zero, Negative, Carry, Overflow}, {28'd0, zncv});
    check({tag, "_rdy_in_done"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUOp = 3'd0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", {16'd0, Result}, 32'd0);
    check("rst_flags", {28'd0, Zero, Negative, Carry, Overflow}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_vec("add1", 16'h000A, 16'h0005, 3'b000, 16'h000F, 4'b0000, 1);
    run_vec("add2", 16'h7FFF, 16'h0001, 3'b000, 16'h8000, 4'b0101, 1);
    run_vec("add3", 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 4'b1010, 1);
    run_vec("sub1", 16'h0005, 16'h0005, 3'b001, 16'h0000, 4'b1010, 1);
    run_vec("sub2", 16'h0000, 16'h0001, 3'b001, 16'hFFFF, 4'b0100, 1);
    run_vec("sub3", 16'h8000, 16'h0001, 3'b001, 16'h7FFF, 4'b0011, 1);
    run_vec("and",  16'h00FF, 16'h0F0F, 3'b010, 16'h000F, 4'b0000, 1);
    run_vec("or",   16'h00FF, 16'h0F0F, 3'b011, 16'h0FFF, 4'b0000, 1);
    run_vec("xor",  16'h00FF, 16'h0F0F, 3'b101, 16'h0FF0, 4'b0000, 1);
    run_vec("not",  16'h00FF, 16'h0F0F, 3'b100, 16'hFF00, 4'b0100, 1);
    run_vec("shl3", 16'h8001, 16'h0003, 3'b110, 16'h0008, 4'b0000, 4);
    run_vec("shl1", 16'h8001, 16'h0001, 3'b110, 16'h0002, 4'b0010, 2);
    run_vec("shl0", 16'h8001, 16'h0000, 3'b110, 16'h8001, 4'b0100, 1);
    run_vec("shl16", 16'h0001, 16'h0010, 3'b110, 16'h0001, 4'b0000, 1);
    run_vec("shl15", 16'h0001, 16'h000F, 3'b110, 16'h8000, 4'b0100, 16);
`ifdef ALU_MUL_EN
    run_vec("mul1", 16'h0012, 16'h0034, 3'b111, 16'h03A8, 4'b0000, 17);
    run_vec("mul2", 16'h1000, 16'h0010, 3'b111, 16'h0000, 4'b1010, 17);
`else
    run_vec("mul_off", 16'h0012, 16'h0034, 3'b111, 16'h0000, 4'b1000, 1);
`endif

    // Backpressure: result held, no new acceptance while DONE waits.
    start_op(16'h000A, 16'h0005, 3'b000);
    wait_done(l);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", {16'd0, Result}, 32'h000F);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_no_overlap", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    check("bp_released", {31'd0, out_valid}, 32'd0);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);

    // out_ready held high before the result exists must not skip anything.
    out_ready = 1'b1;
    start_op(16'h0001, 16'h0002, 3'b000);
    check("early_rdy_valid", {31'd0, out_valid}, 32'd1);
    check("early_rdy_result", {16'd0, Result}, 32'h0003);
    tick();
    out_ready = 1'b0;
    check("early_rdy_done", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multi-cycle op.
`ifdef ALU_MUL_EN
    start_op(16'h0012, 16'h0034, 3'b111);
`else
    start_op(16'h0001, 16'h000F, 3'b110);
`endif
    repeat (3) tick();
    check("exec_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {16'd0, Result}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("abort_recover_rdy", {31'd0, in_ready}, 32'd1);
    run_vec("after_abort", 16'h1234, 16'h0001, 3'b000, 16'h1235, 4'b0000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
